// File: rtl/requant_packer.sv
// Packs signed requantized elements into LANES-wide words and buffers them in a small output FIFO.
// Optional fused ReLU on incoming elements is enabled by defining PACK_RELU_EN.
module requant_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_in,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              flush_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*DATA_WIDTH-1:0]       out_data,
  output logic [LANES-1:0]                  out_keep,
  output logic                              out_last,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int WW = LANES * DATA_WIDTH;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]         lane_cnt;
  logic [WW-1:0]         asm_word;
  logic [DATA_WIDTH-1:0] elem;
  logic [CW:0]           fill;
  logic                  full_close;
  logic                  flush_close;
  logic                  close;
  logic [WW-1:0]         close_word;
  logic [LANES-1:0]      close_keep;

  logic                  pend_valid;
  logic [WW-1:0]         pend_data;
  logic [LANES-1:0]      pend_keep;
  logic                  pend_last;

  logic [WW-1:0]         mem_data [FIFO_DEPTH];
  logic [LANES-1:0]      mem_keep [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         count;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;

  // fill counts lanes occupied once this cycle's element (if any) is inserted
  always_comb begin
`ifdef PACK_RELU_EN
    elem = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
    elem = data_in;
`endif
    fill        = {1'b0, lane_cnt} + {{CW{1'b0}}, valid_in};
    full_close  = valid_in && (lane_cnt == CW'(LANES - 1));
    flush_close = flush_in && (fill != '0);
    close       = full_close || flush_close;
    close_word  = asm_word;
    if (valid_in)
      close_word[int'(lane_cnt) * DATA_WIDTH +: DATA_WIDTH] = elem;
    for (int i = 0; i < LANES; i++)
      close_keep[i] = (i < int'(fill));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt   <= '0;
      asm_word   <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_keep  <= '0;
      pend_last  <= 1'b0;
    end else begin
      pend_valid <= close;
      if (close) begin
        pend_data <= close_word;
        pend_keep <= close_keep;
        pend_last <= flush_in;
        lane_cnt  <= '0;
        asm_word  <= '0;
      end else if (valid_in) begin
        asm_word <= close_word;
        lane_cnt <= lane_cnt + 1'b1;
      end
    end
  end

  // A same-cycle pop frees the head slot, so a full FIFO can still accept the word
  assign fifo_full = (count == LW'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = pend_valid && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= pend_data;
      mem_keep[wr_ptr] <= pend_keep;
      mem_last[wr_ptr] <= pend_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (pend_valid && !push)
        overflow <= 1'b1;
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem_data[rd_ptr] : '0;
  assign out_keep   = out_valid ? mem_keep[rd_ptr] : '0;
  assign out_last   = out_valid ? mem_last[rd_ptr] : 1'b0;
  assign fifo_level = count;

endmodule

// File: tb/tb_requant_packer.sv
// Self-checking bench for requant_packer: word-level reference model plus directed and random stimulus.
// Honours PACK_RELU_EN the same way as the design.
module tb_requant_packer;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        flush_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        overflow;
  logic [2:0]  fifo_level;

  requant_packer #(.DATA_WIDTH(8), .LANES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .flush_in(flush_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .overflow(overflow), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    bit          last;
  } word_t;

  int    checks = 0;
  int    failures = 0;
  int    delivered = 0;
  word_t mq[$];
  word_t pend_word;
  bit    pend_v = 0;
  bit    movf = 0;
  logic [7:0] mlanes[4];
  int    mcnt = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] relu(input logic [7:0] d);
`ifdef PACK_RELU_EN
    return d[7] ? 8'h00 : d;
`else
    return d;
`endif
  endfunction

  // Words become visible one edge after the closing element, then sit in a 4-deep queue
  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit f, input bit r, input bit rs);
    word_t w;
    valid_in  = v;
    data_in   = d;
    flush_in  = f;
    out_ready = r;
    rst       = rs;
    if (!rs && out_valid === 1'b1 && r) delivered++;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      pend_v = 0;
      movf = 0;
      mcnt = 0;
    end else begin
      if (mq.size() > 0 && r) mq.delete(0);
      if (pend_v) begin
        if (mq.size() < 4) mq.push_back(pend_word);
        else movf = 1;
      end
      pend_v = 0;
      if (v) begin
        mlanes[mcnt] = relu(d);
        mcnt++;
      end
      if (mcnt == 4 || (f && mcnt > 0)) begin
        w.data = 32'h0;
        for (int i = 0; i < mcnt; i++) w.data[8*i +: 8] = mlanes[i];
        w.keep = 4'((1 << mcnt) - 1);
        w.last = f;
        pend_word = w;
        pend_v = 1;
        mcnt = 0;
      end
    end
    #1;
    checkOutput("out_valid", out_valid, mq.size() > 0);
    checkOutput("fifo_level", fifo_level, mq.size());
    checkOutput("overflow", overflow, movf);
    if (mq.size() > 0) begin
      checkOutput("out_data", out_data, mq[0].data);
      checkOutput("out_keep", out_keep, mq[0].keep);
      checkOutput("out_last", out_last, mq[0].last);
    end
  endtask

  logic [31:0] drain_exp[4];
  logic [31:0] relu_exp;

  initial begin
    drain_exp[0] = 32'h03020100;
    drain_exp[1] = 32'h07060504;
    drain_exp[2] = 32'h0B0A0908;
    drain_exp[3] = 32'h0F0E0D0C;
`ifdef PACK_RELU_EN
    relu_exp = 32'h05007F00;
`else
    relu_exp = 32'h05FF7F80;
`endif

    applyStimulus(1, 8'h11, 0, 1, 1);
    applyStimulus(1, 8'h22, 0, 1, 1);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_out_keep", out_keep, 4'h0);
    checkOutput("rst_out_last", out_last, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 0, 1, 0);

    for (int i = 1; i <= 4; i++) applyStimulus(1, 8'(i), 0, 1, 0);
    checkOutput("full_latency", out_valid, 1'b0);
    applyStimulus(0, 8'h00, 0, 1, 0);
    checkOutput("full_valid", out_valid, 1'b1);
    checkOutput("full_data", out_data, 32'h04030201);
    checkOutput("full_keep", out_keep, 4'b1111);
    checkOutput("full_last", out_last, 1'b0);
    applyStimulus(0, 8'h00, 0, 1, 0);
    checkOutput("full_one_cycle", out_valid, 1'b0);

    applyStimulus(1, 8'hAA, 0, 1, 0);
    applyStimulus(1, 8'hBB, 1, 1, 0);
    applyStimulus(0, 8'h00, 0, 1, 0);
    checkOutput("flush_data", out_data, 32'h0000BBAA);
    checkOutput("flush_keep", out_keep, 4'b0011);
    checkOutput("flush_last", out_last, 1'b1);
    applyStimulus(0, 8'h00, 0, 1, 0);
    applyStimulus(0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 0, 1, 0);
    checkOutput("lone_flush", out_valid, 1'b0);

    for (int i = 0; i < 20; i++) applyStimulus(1, 8'(i), 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("ovf_level", fifo_level, 3'd4);
    checkOutput("ovf_flag", overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("drain_word", out_data, drain_exp[k]);
      applyStimulus(0, 8'h00, 0, 1, 0);
    end
    checkOutput("drain_empty", out_valid, 1'b0);
    applyStimulus(0, 8'h00, 0, 1, 1);
    checkOutput("ovf_cleared", overflow, 1'b0);

    delivered = 0;
    for (int i = 0; i < 64; i++)
      applyStimulus(1, 8'($urandom), 0, ($urandom_range(0, 1) == 1) || (i % 4 == 0), 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 8'h00, 0, 1, 0);
    checkOutput("bp_delivered", delivered, 16);
    checkOutput("bp_no_ovf", overflow, 1'b0);

    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0, 1, 0);
    applyStimulus(0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 0, 1, 0);

    applyStimulus(1, 8'h80, 0, 1, 0);
    applyStimulus(1, 8'h7F, 0, 1, 0);
    applyStimulus(1, 8'hFF, 0, 1, 0);
    applyStimulus(1, 8'h05, 0, 1, 0);
    applyStimulus(0, 8'h00, 0, 1, 0);
    checkOutput("relu_data", out_data, relu_exp);
    applyStimulus(0, 8'h00, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/requant_packer.md
# requant_packer

Packs the signed 8-bit requantized results from the scaling unit into 32-bit words for the output write path. It sits directly downstream of the scaling unit and consumes its `valid_out`/`data_out` stream, which has no backpressure. Completed words are buffered in a small FIFO and presented on a valid/ready interface. An explicit flush emits a partial final word with a byte-keep mask.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: width of one input element (signed).
- `LANES`, 4: elements per output word. Output word width is `LANES*DATA_WIDTH`.
- `FIFO_DEPTH`, 4: output FIFO depth in words. Must be a power of 2 and at least 2.

**Ports** (one clock; reset is synchronous and active-high)
- `clk`, input, 1: clock. All logic updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `valid_in`, input, 1: `data_in` is valid this cycle. Upstream cannot stall.
- `data_in`, input, `DATA_WIDTH`: signed requantized element.
- `flush_in`, input, 1: close the current word after including any same-cycle `valid_in` element.
- `out_valid`, output, 1: FIFO head word is valid.
- `out_ready`, input, 1: consumer accepts the head word.
- `out_data`, output, `LANES*DATA_WIDTH`: packed word. Lane i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `out_keep`, output, `LANES`: per-lane valid mask.
- `out_last`, output, 1: word was closed by a flush.
- `overflow`, output, 1: sticky; set when a word was dropped.
- `fifo_level`, output, `$clog2(FIFO_DEPTH+1)`: number of words currently stored.

## Operation

**Assembly**
- A lane counter (0..`LANES`-1) and an assembly register track the word being built.
- Each `valid_in` writes `data_in` into lane[counter] and increments the counter.
- Lanes not yet written are held at zero.

**Word closing**
- Full close: `valid_in` while counter = `LANES`-1. The word is pushed with `keep` = all ones and `last` = `flush_in`.
- Flush close: `flush_in` with at least one lane filled, counting any same-cycle `valid_in`. The word is pushed with zero padding, `keep` set to the filled lanes, and `last`=1.
- `flush_in` with no filled lanes and no `valid_in` is a no-op: no word is pushed.
- After any close, the counter and assembly register return to zero.

**FIFO**
- Synchronous FIFO with a registered write.
- The head word drives `out_data`, `out_keep` and `out_last`.
- `out_valid` = FIFO not empty.
- A pop occurs on `out_valid && out_ready`.
- Push and pop in the same cycle are both performed, including when the FIFO is full. The pop frees the slot first.

**Overflow**
- A push while the FIFO is full with no same-cycle pop drops the new word.
- FIFO contents are unchanged on a drop.
- `overflow` is set and stays high until `rst`.
- The assembly state still clears, so the stream stays lane-aligned.

**Throughput and handshake**
- The block accepts one element per cycle and produces one word per `LANES` elements.
- With `out_ready` held high, no overflow can occur.
- While `out_valid && !out_ready`, `out_data`, `out_keep` and `out_last` must remain stable.

## Timing

**Reset**
- `rst` high at a clock edge clears all state: lane counter=0, assembly register=0, FIFO empty, `overflow`=0.
- Resulting output values: `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0, `fifo_level`=0.
- Reset mid-word discards the partial word with no output.
- Reset takes priority over `valid_in`, `flush_in` and `out_ready` in the same cycle.

**Latency**
- If the element that closes a word arrives at edge N, that word is visible with `out_valid`=1 after edge N+1 when the FIFO was empty.
- `fifo_level` updates on the same edge as the push or pop.

**Boundaries**
- Full + push + pop: level unchanged, no overflow.
- Empty + pop request: ignored.
- Full close and flush in the same cycle: a single word with `last`=1.

## Configuration

- `PACK_RELU_EN` defined: each incoming element with its sign bit set is replaced by 0 before lane insertion. This gives a fused ReLU on requantized outputs.
- `PACK_RELU_EN` undefined: elements are packed unchanged, including negative values.
- Keep masks, latency and all other behaviour are identical in both builds.

## Test plan

- **Reset:** hold `rst` for 2 cycles with `valid_in`=1 → `out_valid`=0, `overflow`=0, `fifo_level`=0, and no word appears afterwards.
- **Full word:** drive bytes 0x01, 0x02, 0x03, 0x04 on consecutive cycles with `out_ready`=1 → one cycle after the 4th byte, `out_data`=0x04030201, `out_keep`=4'b1111, `out_last`=0, and `out_valid` is high for exactly 1 cycle.
- **Flush:** drive 0xAA, then 0xBB with `flush_in` in the 0xBB cycle → `out_data`=0x0000BBAA, `out_keep`=4'b0011, `out_last`=1. A following lone `flush_in` produces no word.
- **Overflow:** hold `out_ready`=0 and drive 20 bytes 0x00..0x13 → `fifo_level`=4, `overflow`=1, and the 5th word (0x13121110) is dropped. Then set `out_ready`=1 → words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C drain on 4 consecutive cycles.
- **Backpressure:** toggle `out_ready` randomly while streaming 64 bytes → outputs stay stable while stalled, every word is delivered in order, and `overflow` stays 0 as long as ready duty ≥ 1/4.
- **ReLU build:** drive bytes 0x80, 0x7F, 0xFF, 0x05 → with `PACK_RELU_EN`, `out_data`=0x05007F00; without it, `out_data`=0x05FF7F80.
